regfile_write_arbiter: RTL and testbench

- Shares the register file's single write port between the pipeline WB stage and a long-latency unit (mult/div result path).
- Tracks outstanding long-unit destinations in a busy scoreboard so decode can detect RAW hazards.
- Forces a pipeline bubble when the long unit has waited too long for the port.
- Sits between WB, the long unit and the register file write inputs (regWrite/writeReg/writeData).

---
 rtl/regfile_write_arbiter.sv | 128 ++++++++++++
 tb/tb_regfile_write_arbiter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - register-file write-port arbiter between WB and the long-latency unit
// Optional macro REGARB_STATS_EN adds saturating conflict_cnt / force_cnt statistics outputs.
module regfile_write_arbiter #(
  parameter int ADDR_W       = 5,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wb_we,
  input  logic [ADDR_W-1:0]        wb_addr,
  input  logic [DATA_W-1:0]        wb_data,
  input  logic                     lu_issue,
  input  logic [ADDR_W-1:0]        lu_issue_addr,
  input  logic                     lu_valid,
  input  logic [ADDR_W-1:0]        lu_addr,
  input  logic [DATA_W-1:0]        lu_data,
  output logic                     lu_ready,
  output logic                     rf_regWrite,
  output logic [ADDR_W-1:0]        rf_writeReg,
  output logic [DATA_W-1:0]        rf_writeData,
  output logic                     stall_pipe,
  output logic [(1<<ADDR_W)-1:0]   busy_mask,
  input  logic [ADDR_W-1:0]        chk_addr1,
  input  logic [ADDR_W-1:0]        chk_addr2,
  output logic                     chk_hazard
`ifdef REGARB_STATS_EN
  ,
  output logic [15:0]              conflict_cnt,
  output logic [15:0]              force_cnt
`endif
);

  localparam int NREG = 1 << ADDR_W;

  typedef enum logic [1:0] {IDLE, WAIT, FORCE} state_t;

  state_t     state;
  logic [3:0] cnt;

  logic wbReal;
  logic luGrant;
  logic xfer;
  logic luBlocked;
  logic forceEntry;
  logic [NREG-1:0] setMask;
  logic [NREG-1:0] clrMask;

  assign wbReal    = wb_we && (wb_addr != '0);
  assign lu_ready  = lu_valid && !wbReal;
  assign luGrant   = lu_ready && (lu_addr != '0);
  assign xfer      = lu_valid && lu_ready;
  assign luBlocked = lu_valid && !lu_ready;

  assign rf_regWrite  = wbReal || luGrant;
  assign rf_writeReg  = luGrant ? lu_addr : wb_addr;
  assign rf_writeData = luGrant ? lu_data : wb_data;

  assign forceEntry = (state == WAIT) && luBlocked && (cnt == 4'(STARVE_LIMIT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      stall_pipe <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (luBlocked) begin
            state <= WAIT;
            cnt   <= 4'd1;
          end
        end
        WAIT: begin
          // A dropped lu_valid also lands here; nothing is remembered about it.
          if (!lu_valid || lu_ready) begin
            state <= IDLE;
            cnt   <= 4'd0;
          end else if (forceEntry) begin
            state      <= FORCE;
            stall_pipe <= 1'b1;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        FORCE: begin
          if (!lu_valid || lu_ready) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            stall_pipe <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          cnt        <= 4'd0;
          stall_pipe <= 1'b0;
        end
      endcase
    end
  end

  // Set is applied after clear so a same-cycle reissue keeps the register busy.
  assign setMask = (lu_issue && (lu_issue_addr != '0)) ? (NREG'(1) << lu_issue_addr) : '0;
  assign clrMask = xfer ? (NREG'(1) << lu_addr) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_mask <= '0;
    end else begin
      busy_mask <= ((busy_mask & ~clrMask) | setMask) & ~NREG'(1);
    end
  end

  assign chk_hazard = busy_mask[chk_addr1] | busy_mask[chk_addr2];

`ifdef REGARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict_cnt <= 16'd0;
      force_cnt    <= 16'd0;
    end else begin
      if (luBlocked && (conflict_cnt != 16'hFFFF)) conflict_cnt <= conflict_cnt + 16'd1;
      if (forceEntry && (force_cnt != 16'hFFFF))   force_cnt    <= force_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - scoreboard bench for regfile_write_arbiter
// Directed stimulus pushes per-cycle expectations; a negedge monitor pops and compares.
module tb_regfile_write_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        lu_issue;
  logic [4:0]  lu_issue_addr;
  logic        lu_valid;
  logic [4:0]  lu_addr;
  logic [31:0] lu_data;
  logic        lu_ready;
  logic        rf_regWrite;
  logic [4:0]  rf_writeReg;
  logic [31:0] rf_writeData;
  logic        stall_pipe;
  logic [31:0] busy_mask;
  logic [4:0]  chk_addr1;
  logic [4:0]  chk_addr2;
  logic        chk_hazard;
`ifdef REGARB_STATS_EN
  logic [15:0] conflict_cnt;
  logic [15:0] force_cnt;
`endif

  always #5 clk = ~clk;

  regfile_write_arbiter #(.ADDR_W(5), .DATA_W(32), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .lu_issue(lu_issue), .lu_issue_addr(lu_issue_addr),
    .lu_valid(lu_valid), .lu_addr(lu_addr), .lu_data(lu_data), .lu_ready(lu_ready),
    .rf_regWrite(rf_regWrite), .rf_writeReg(rf_writeReg), .rf_writeData(rf_writeData),
    .stall_pipe(stall_pipe), .busy_mask(busy_mask),
    .chk_addr1(chk_addr1), .chk_addr2(chk_addr2), .chk_hazard(chk_hazard)
`ifdef REGARB_STATS_EN
    , .conflict_cnt(conflict_cnt), .force_cnt(force_cnt)
`endif
  );

  typedef struct {
    string       tag;
    logic        ready;
    logic        rw;
    logic [4:0]  wreg;
    logic [31:0] wdata;
    logic        stall;
    logic [31:0] busy;
    logic        haz;
    logic        statsChk;
    logic [15:0] conf;
    logic [15:0] forc;
  } exp_t;

  exp_t q[$];
  int   nVec = 0;
  int   nMis = 0;

  logic        statsChk = 1'b0;
  logic [15:0] eConf = 16'd0;
  logic [15:0] eForce = 16'd0;

  task automatic cmp(input string tag, input string field, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nMis++;
      $display("FAIL %s.%s: got 0x%0h expected 0x%0h", tag, field, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      cmp(e.tag, "lu_ready", 32'(lu_ready), 32'(e.ready));
      cmp(e.tag, "rf_regWrite", 32'(rf_regWrite), 32'(e.rw));
      if (e.rw) begin
        cmp(e.tag, "rf_writeReg", 32'(rf_writeReg), 32'(e.wreg));
        cmp(e.tag, "rf_writeData", rf_writeData, e.wdata);
      end
      cmp(e.tag, "stall_pipe", 32'(stall_pipe), 32'(e.stall));
      cmp(e.tag, "busy_mask", busy_mask, e.busy);
      cmp(e.tag, "chk_hazard", 32'(chk_hazard), 32'(e.haz));
`ifdef REGARB_STATS_EN
      if (e.statsChk) begin
        cmp(e.tag, "conflict_cnt", 32'(conflict_cnt), 32'(e.conf));
        cmp(e.tag, "force_cnt", 32'(force_cnt), 32'(e.forc));
      end
`endif
    end
  end

  task automatic idle();
    wb_we = 0; wb_addr = 0; wb_data = 0;
    lu_issue = 0; lu_issue_addr = 0;
    lu_valid = 0; lu_addr = 0; lu_data = 0;
    chk_addr1 = 0; chk_addr2 = 0;
  endtask

  task automatic wb(input logic [4:0] a, input logic [31:0] d);
    wb_we = 1; wb_addr = a; wb_data = d;
  endtask

  task automatic lu(input logic [4:0] a, input logic [31:0] d);
    lu_valid = 1; lu_addr = a; lu_data = d;
  endtask

  task automatic issue(input logic [4:0] a);
    lu_issue = 1; lu_issue_addr = a;
  endtask

  task automatic step(input string tag, input logic ready, input logic rw, input logic [4:0] wreg,
                      input logic [31:0] wdata, input logic stall, input logic [31:0] busy, input logic haz);
    exp_t e;
    e.tag = tag; e.ready = ready; e.rw = rw; e.wreg = wreg; e.wdata = wdata;
    e.stall = stall; e.busy = busy; e.haz = haz;
    e.statsChk = statsChk; e.conf = eConf; e.forc = eForce;
    statsChk = 1'b0;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    step("reset", 0, 0, 0, 0, 0, 32'h0, 0);

    // WB only
    wb(5'd5, 32'hDEADBEEF);
    step("wb_only", 0, 1, 5'd5, 32'hDEADBEEF, 0, 32'h0, 0);

    // Conflict: issue reg 9, result two cycles later against two WB writes
    idle(); issue(5'd9);
    step("cf_issue", 0, 0, 0, 0, 0, 32'h0, 0);
    idle();
    step("cf_gap", 0, 0, 0, 0, 0, 32'h200, 0);
    wb(5'd3, 32'h0000AAAA); lu(5'd9, 32'h1234);
    step("cf_blk0", 0, 1, 5'd3, 32'h0000AAAA, 0, 32'h200, 0);
    step("cf_blk1", 0, 1, 5'd3, 32'h0000AAAA, 0, 32'h200, 0);
    wb_we = 0;
    step("cf_grant", 1, 1, 5'd9, 32'h1234, 0, 32'h200, 0);
    idle();
    step("cf_done", 0, 0, 0, 0, 0, 32'h0, 0);

    // Starvation: stall_pipe appears in the sixth blocked cycle
    wb(5'd2, 32'h1111); lu(5'd4, 32'h5555);
    for (int i = 0; i < 5; i++) step("sv_wait", 0, 1, 5'd2, 32'h1111, 0, 32'h0, 0);
    step("sv_force0", 0, 1, 5'd2, 32'h1111, 1, 32'h0, 0);
    step("sv_force1", 0, 1, 5'd2, 32'h1111, 1, 32'h0, 0);
    wb_we = 0;
    step("sv_grant", 1, 1, 5'd4, 32'h5555, 1, 32'h0, 0);
    idle();
    step("sv_release", 0, 0, 0, 0, 0, 32'h0, 0);

    // Register zero on both paths
    wb(5'd0, 32'hFFFF); lu(5'd7, 32'h77); issue(5'd0);
    step("z_wb0", 1, 1, 5'd7, 32'h77, 0, 32'h0, 0);
    idle(); lu(5'd0, 32'h99);
    step("z_lu0", 1, 0, 0, 0, 0, 32'h0, 0);
    idle();
    step("z_busy", 0, 0, 0, 0, 0, 32'h0, 0);

    // Scoreboard hazards, set-wins and reissue to a busy register
    issue(5'd12);
    step("h_issue", 0, 0, 0, 0, 0, 32'h0, 0);
    idle(); chk_addr1 = 5'd12;
    step("h_haz1", 0, 0, 0, 0, 0, 32'h1000, 1);
    idle(); issue(5'd12); lu(5'd12, 32'hC); chk_addr2 = 5'd12;
    step("h_setclr", 1, 1, 5'd12, 32'hC, 0, 32'h1000, 1);
    idle(); issue(5'd12); chk_addr2 = 5'd12;
    step("h_reissue", 0, 0, 0, 0, 0, 32'h1000, 1);
    idle(); lu(5'd12, 32'hD); chk_addr2 = 5'd12;
    step("h_clear", 1, 1, 5'd12, 32'hD, 0, 32'h1000, 1);
    idle(); chk_addr2 = 5'd12;
    step("h_free", 0, 0, 0, 0, 0, 32'h0, 0);

    // Reach FORCE with regs 9 and 10 busy, then reset asynchronously
    idle(); issue(5'd9);
    step("f_iss9", 0, 0, 0, 0, 0, 32'h0, 0);
    idle(); issue(5'd10);
    step("f_iss10", 0, 0, 0, 0, 0, 32'h200, 0);
    idle(); wb(5'd1, 32'h1); lu(5'd9, 32'h9);
    for (int i = 0; i < 5; i++) step("f_wait", 0, 1, 5'd1, 32'h1, 0, 32'h600, 0);
    statsChk = 1'b1; eConf = 16'd14; eForce = 16'd2;
    step("f_force", 0, 1, 5'd1, 32'h1, 1, 32'h600, 0);
    rst_n = 1'b0;
    statsChk = 1'b1; eConf = 16'd0; eForce = 16'd0;
    step("rst_async", 0, 1, 5'd1, 32'h1, 0, 32'h0, 0);
    idle();
    step("rst_hold", 0, 0, 0, 0, 0, 32'h0, 0);
    rst_n = 1'b1;
    step("post_rst", 0, 0, 0, 0, 0, 32'h0, 0);

    for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
    #1;
    nVec++;
    if (q.size() != 0) begin
      nMis++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
